// File: rtl/gpr.sv
// Integer general-purpose register file: WBU write port with valid/ready handshake,
// two combinational IDU read ports with write bypass, busy scoreboard and retired-write counter.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_INIT | first cycle after reset; writebacks refused, issues ignored
// ST_RUN  | normal operation; one writeback accepted per cycle

module gpr #(
    parameter int DATA_W   = 32,
    parameter int GPR_NUM  = 32,
    parameter int GPR_ID_W = $clog2(GPR_NUM),
    parameter int CNT_W    = 32
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_wbu_valid,
    output logic                o_gpr_ready,
    input  logic                i_wbu_gpr_wr_en,
    input  logic [GPR_ID_W-1:0] i_wbu_gpr_wr_id,
    input  logic [DATA_W-1:0]   i_wbu_gpr_wr_data,
    input  logic [GPR_ID_W-1:0] i_idu_rd_id_1,
    input  logic [GPR_ID_W-1:0] i_idu_rd_id_2,
    output logic [DATA_W-1:0]   o_gpr_rd_data_1,
    output logic [DATA_W-1:0]   o_gpr_rd_data_2,
    output logic                o_gpr_rd_busy_1,
    output logic                o_gpr_rd_busy_2,
    input  logic                i_idu_issue_en,
    input  logic [GPR_ID_W-1:0] i_idu_issue_id,
    output logic [CNT_W-1:0]    o_gpr_wr_cnt
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [DATA_W-1:0]   regs_q [GPR_NUM];
    logic [GPR_NUM-1:0]  busy_q;
    logic [CNT_W-1:0]    cnt_q;

    logic                accept;
    logic                wr_fire;
    logic                issue_set;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= ST_INIT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_INIT: state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    // Gated by i_rst_n so a writeback presented during the reset cycle is never accepted.
    always_comb begin
        o_gpr_ready = 1'b0;
        if (state_q == ST_RUN) begin
            o_gpr_ready = i_rst_n;
        end
    end

    // ------------------------------------------------------------------
    // Handshake / write qualification
    // ------------------------------------------------------------------
    assign accept    = i_wbu_valid & o_gpr_ready;
    assign wr_fire   = accept & i_wbu_gpr_wr_en & (i_wbu_gpr_wr_id != '0);
    assign issue_set = i_idu_issue_en & (state_q == ST_RUN) & (i_idu_issue_id != '0);

    // ------------------------------------------------------------------
    // Register storage; entry 0 is never written and never read back
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < GPR_NUM; i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_fire) begin
            regs_q[i_wbu_gpr_wr_id] <= i_wbu_gpr_wr_data;
        end
    end

    // ------------------------------------------------------------------
    // Busy scoreboard: a same-cycle issue wins over a writeback clear,
    // because the issue names a newer producer still in flight.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            for (int i = 1; i < GPR_NUM; i++) begin
                if (issue_set && (i_idu_issue_id == GPR_ID_W'(i))) begin
                    busy_q[i] <= 1'b1;
                end else if (wr_fire && (i_wbu_gpr_wr_id == GPR_ID_W'(i))) begin
                    busy_q[i] <= 1'b0;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Retired-write counter, wraps naturally
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (wr_fire) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign o_gpr_wr_cnt = cnt_q;

    // ------------------------------------------------------------------
    // Read ports with write bypass
    // ------------------------------------------------------------------
    always_comb begin
        o_gpr_rd_data_1 = '0;
        o_gpr_rd_busy_1 = 1'b0;
        if (i_idu_rd_id_1 != '0) begin
            if (wr_fire && (i_wbu_gpr_wr_id == i_idu_rd_id_1)) begin
                o_gpr_rd_data_1 = i_wbu_gpr_wr_data;
                o_gpr_rd_busy_1 = 1'b0;
            end else begin
                o_gpr_rd_data_1 = regs_q[i_idu_rd_id_1];
                o_gpr_rd_busy_1 = busy_q[i_idu_rd_id_1];
            end
        end
    end

    always_comb begin
        o_gpr_rd_data_2 = '0;
        o_gpr_rd_busy_2 = 1'b0;
        if (i_idu_rd_id_2 != '0) begin
            if (wr_fire && (i_wbu_gpr_wr_id == i_idu_rd_id_2)) begin
                o_gpr_rd_data_2 = i_wbu_gpr_wr_data;
                o_gpr_rd_busy_2 = 1'b0;
            end else begin
                o_gpr_rd_data_2 = regs_q[i_idu_rd_id_2];
                o_gpr_rd_busy_2 = busy_q[i_idu_rd_id_2];
            end
        end
    end

endmodule

// File: tb/tb_gpr.sv
// Directed bench for gpr: per-cycle vector table plus a counter-wrap sequence
// on a narrow-counter instance.

module tb_gpr;

    logic        clk;
    logic        rst_n;
    logic        wbu_valid;
    logic        gpr_ready;
    logic        wr_en;
    logic [4:0]  wr_id;
    logic [31:0] wr_data;
    logic [4:0]  rd_id_1;
    logic [4:0]  rd_id_2;
    logic [31:0] rd_data_1;
    logic [31:0] rd_data_2;
    logic        rd_busy_1;
    logic        rd_busy_2;
    logic        issue_en;
    logic [4:0]  issue_id;
    logic [31:0] wr_cnt;

    // narrow-counter instance
    logic        w_rst_n;
    logic        w_valid;
    logic        w_ready;
    logic        w_wr_en;
    logic [4:0]  w_wr_id;
    logic [31:0] w_wr_data;
    logic [4:0]  w_rd_id;
    logic [31:0] w_rd_data_1;
    logic [31:0] w_rd_data_2;
    logic        w_busy_1;
    logic        w_busy_2;
    logic [2:0]  w_cnt;

    int errors = 0;
    int checks = 0;

    gpr dut (
        .i_clk             (clk),
        .i_rst_n           (rst_n),
        .i_wbu_valid       (wbu_valid),
        .o_gpr_ready       (gpr_ready),
        .i_wbu_gpr_wr_en   (wr_en),
        .i_wbu_gpr_wr_id   (wr_id),
        .i_wbu_gpr_wr_data (wr_data),
        .i_idu_rd_id_1     (rd_id_1),
        .i_idu_rd_id_2     (rd_id_2),
        .o_gpr_rd_data_1   (rd_data_1),
        .o_gpr_rd_data_2   (rd_data_2),
        .o_gpr_rd_busy_1   (rd_busy_1),
        .o_gpr_rd_busy_2   (rd_busy_2),
        .i_idu_issue_en    (issue_en),
        .i_idu_issue_id    (issue_id),
        .o_gpr_wr_cnt      (wr_cnt)
    );

    gpr #(.CNT_W(3)) dut_w (
        .i_clk             (clk),
        .i_rst_n           (w_rst_n),
        .i_wbu_valid       (w_valid),
        .o_gpr_ready       (w_ready),
        .i_wbu_gpr_wr_en   (w_wr_en),
        .i_wbu_gpr_wr_id   (w_wr_id),
        .i_wbu_gpr_wr_data (w_wr_data),
        .i_idu_rd_id_1     (w_rd_id),
        .i_idu_rd_id_2     (w_rd_id),
        .o_gpr_rd_data_1   (w_rd_data_1),
        .o_gpr_rd_data_2   (w_rd_data_2),
        .o_gpr_rd_busy_1   (w_busy_1),
        .o_gpr_rd_busy_2   (w_busy_2),
        .i_idu_issue_en    (1'b0),
        .i_idu_issue_id    (5'd0),
        .o_gpr_wr_cnt      (w_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        valid;
        logic        wr_en;
        logic [4:0]  wr_id;
        logic [31:0] wr_data;
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic        issue_en;
        logic [4:0]  issue_id;
        logic        e_ready;
        logic [31:0] e_rd1;
        logic [31:0] e_rd2;
        logic        e_busy1;
        logic        e_busy2;
        logic [31:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic r, input logic v, input logic we, input logic [4:0] wid,
                           input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                           input logic ie, input logic [4:0] iid, input logic er,
                           input logic [31:0] ed1, input logic [31:0] ed2, input logic eb1,
                           input logic eb2, input logic [31:0] ec);
        vec_t t;
        t.rst_n = r;  t.valid = v;  t.wr_en = we;  t.wr_id = wid;  t.wr_data = wd;
        t.rd1 = r1;   t.rd2 = r2;   t.issue_en = ie;  t.issue_id = iid;
        t.e_ready = er;  t.e_rd1 = ed1;  t.e_rd2 = ed2;
        t.e_busy1 = eb1; t.e_busy2 = eb2; t.e_cnt = ec;
        vecs.push_back(t);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; wbu_valid = 1'b0; wr_en = 1'b0; wr_id = '0; wr_data = '0;
        rd_id_1 = '0; rd_id_2 = '0; issue_en = 1'b0; issue_id = '0;
        w_rst_n = 1'b0; w_valid = 1'b0; w_wr_en = 1'b0; w_wr_id = '0; w_wr_data = '0;
        w_rd_id = '0;

        //       rst v  we id  data          rd1 rd2 ie iid  rdy rd1_exp       rd2_exp       b1 b2 cnt
        add_vec(0, 0, 0, 0,  32'h0,        5,  0,  0, 0,   0, 32'h0,        32'h0,        0, 0, 0);
        add_vec(1, 0, 0, 0,  32'h0,        5,  0,  0, 0,   0, 32'h0,        32'h0,        0, 0, 0);
        add_vec(1, 0, 0, 0,  32'h0,        5,  0,  0, 0,   1, 32'h0,        32'h0,        0, 0, 0);
        add_vec(1, 1, 1, 5,  32'hDEADBEEF, 5,  5,  0, 0,   1, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        add_vec(1, 0, 0, 0,  32'h0,        5,  0,  0, 0,   1, 32'hDEADBEEF, 32'h0,        0, 0, 1);
        add_vec(1, 1, 1, 0,  32'h12345678, 0,  5,  0, 0,   1, 32'h0,        32'hDEADBEEF, 0, 0, 1);
        add_vec(1, 0, 0, 0,  32'h0,        0,  5,  0, 0,   1, 32'h0,        32'hDEADBEEF, 0, 0, 1);
        add_vec(1, 0, 0, 0,  32'h0,        7,  0,  1, 7,   1, 32'h0,        32'h0,        0, 0, 1);
        add_vec(1, 0, 0, 0,  32'h0,        7,  7,  0, 0,   1, 32'h0,        32'h0,        1, 1, 1);
        add_vec(1, 1, 1, 7,  32'h000000A7, 7,  5,  0, 0,   1, 32'h000000A7, 32'hDEADBEEF, 0, 0, 1);
        add_vec(1, 0, 0, 0,  32'h0,        7,  0,  0, 0,   1, 32'h000000A7, 32'h0,        0, 0, 2);
        add_vec(1, 1, 1, 9,  32'h00000099, 9,  0,  1, 9,   1, 32'h00000099, 32'h0,        0, 0, 2);
        add_vec(1, 0, 0, 0,  32'h0,        9,  7,  0, 0,   1, 32'h00000099, 32'h000000A7, 1, 0, 3);
        add_vec(1, 1, 0, 9,  32'h00001234, 9,  0,  0, 0,   1, 32'h00000099, 32'h0,        1, 0, 3);
        add_vec(1, 1, 1, 9,  32'h00000055, 9,  9,  0, 0,   1, 32'h00000055, 32'h00000055, 0, 0, 3);
        add_vec(1, 0, 0, 0,  32'h0,        9,  5,  0, 0,   1, 32'h00000055, 32'hDEADBEEF, 0, 0, 4);
        add_vec(0, 1, 1, 3,  32'h0000AAAA, 3,  9,  0, 0,   0, 32'h0,        32'h00000055, 0, 0, 4);
        add_vec(1, 1, 1, 3,  32'h0000AAAA, 3,  9,  1, 3,   0, 32'h0,        32'h0,        0, 0, 0);
        add_vec(1, 0, 0, 0,  32'h0,        3,  3,  0, 0,   1, 32'h0,        32'h0,        0, 0, 0);
        add_vec(1, 1, 1, 3,  32'h0000AAAA, 3,  0,  0, 0,   1, 32'h0000AAAA, 32'h0,        0, 0, 0);
        add_vec(1, 0, 0, 0,  32'h0,        3,  5,  0, 0,   1, 32'h0000AAAA, 32'h0,        0, 0, 1);

        tick();
        tick();

        for (int i = 0; i < vecs.size(); i++) begin
            rst_n    = vecs[i].rst_n;
            wbu_valid = vecs[i].valid;
            wr_en    = vecs[i].wr_en;
            wr_id    = vecs[i].wr_id;
            wr_data  = vecs[i].wr_data;
            rd_id_1  = vecs[i].rd1;
            rd_id_2  = vecs[i].rd2;
            issue_en = vecs[i].issue_en;
            issue_id = vecs[i].issue_id;
            #1;
            chk($sformatf("v%0d ready", i), 32'(gpr_ready), 32'(vecs[i].e_ready));
            chk($sformatf("v%0d rd1", i), rd_data_1, vecs[i].e_rd1);
            chk($sformatf("v%0d rd2", i), rd_data_2, vecs[i].e_rd2);
            chk($sformatf("v%0d busy1", i), 32'(rd_busy_1), 32'(vecs[i].e_busy1));
            chk($sformatf("v%0d busy2", i), 32'(rd_busy_2), 32'(vecs[i].e_busy2));
            chk($sformatf("v%0d cnt", i), wr_cnt, vecs[i].e_cnt);
            tick();
        end

        // Counter wrap on a 3-bit counter: seven writes reach the all-ones value, the eighth wraps.
        w_rst_n = 1'b1;
        tick();
        chk("wrap ready", 32'(w_ready), 32'd1);
        chk("wrap cnt0", 32'(w_cnt), 32'd0);
        w_valid = 1'b1;
        w_wr_en = 1'b1;
        w_wr_id = 5'd1;
        w_rd_id = 5'd1;
        for (int k = 1; k <= 7; k++) begin
            w_wr_data = 32'(k);
            tick();
        end
        w_valid = 1'b0;
        #1;
        chk("wrap cnt max", 32'(w_cnt), 32'd7);
        chk("wrap data", w_rd_data_1, 32'd7);
        w_valid   = 1'b1;
        w_wr_id   = 5'd0;
        w_wr_data = 32'hFFFF_FFFF;
        tick();
        w_valid = 1'b0;
        #1;
        chk("wrap x0 no count", 32'(w_cnt), 32'd7);
        w_valid   = 1'b1;
        w_wr_id   = 5'd2;
        w_wr_data = 32'h0000_0022;
        tick();
        w_valid = 1'b0;
        w_rd_id = 5'd2;
        #1;
        chk("wrap cnt zero", 32'(w_cnt), 32'd0);
        chk("wrap data2", w_rd_data_2, 32'h0000_0022);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
